// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loaderState_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         BYTE_WIDTH = 8;
    localparam int         WORD_WIDTH = 16;
    localparam int         LEN_WIDTH  = 16;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts idle cycles and flags when the limit is reached.
module byte_timeout #(
    parameter int TimeoutCycles = 1000000
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CountWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    logic [CountWidth-1:0] count;

    assign expired = (count == CountWidth'(TimeoutCycles - 1));

    // Holds at the limit; the owner leaves the frame states and clears us.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// UART-fed boot loader: parses sync/length/payload/checksum frames, writes
// big-endian 16-bit words into instruction memory and gates the CPU.
module program_loader
    import loader_pkg::*;
#(
    parameter int         AddrWidth     = 16,
    parameter int         TimeoutCycles = 1000000,
    parameter logic [7:0] SyncByte      = SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  rxValid,
    input  logic [BYTE_WIDTH-1:0] rxData,
    output logic                  memWriteEnable,
    output logic [AddrWidth-1:0]  memWriteAddr,
    output logic [WORD_WIDTH-1:0] memWriteData,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic                  loadError,
    output logic [LEN_WIDTH-1:0]  wordCount
);

    localparam logic [LEN_WIDTH:0] Depth = (LEN_WIDTH + 1)'(1) << AddrWidth;

    loaderState_t          state;
    loaderState_t          stateNext;
    logic [BYTE_WIDTH-1:0] lenHi;
    logic [LEN_WIDTH-1:0]  lenWords;
    logic [BYTE_WIDTH-1:0] hiByte;
    logic [BYTE_WIDTH-1:0] checksum;
    logic                  idleLike;
    logic                  inFrame;
    logic                  timeoutExpired;
    logic                  syncSeen;

    assign idleLike = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
    assign inFrame  = !idleLike;
    assign syncSeen = idleLike && rxValid && (rxData == SyncByte);

    byte_timeout #(
        .TimeoutCycles(TimeoutCycles)
    ) timeoutCounter (
        .clk    (clk),
        .rstN   (rstN),
        .clear  (rxValid || idleLike),
        .enable (inFrame),
        .expired(timeoutExpired)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (syncSeen) stateNext = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (rxValid) stateNext = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (rxValid) begin
                    if ({1'b0, lenHi, rxData} > Depth) begin
                        stateNext = ST_ERROR;
                    end else if ({lenHi, rxData} == '0) begin
                        stateNext = ST_CHECK;
                    end else begin
                        stateNext = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (rxValid) stateNext = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (rxValid) begin
                    if ((wordCount + 16'd1) == lenWords) begin
                        stateNext = ST_CHECK;
                    end else begin
                        stateNext = ST_DATA_HI;
                    end
                end
            end
            ST_CHECK: begin
                if (rxValid) begin
                    stateNext = (rxData == checksum) ? ST_DONE : ST_ERROR;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
        if (inFrame && timeoutExpired && !rxValid) begin
            stateNext = ST_ERROR;
        end
    end

    // Status flags are registered from the next state so they change together
    // with the state register and never glitch.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            memWriteEnable <= 1'b0;
            memWriteAddr   <= '0;
            memWriteData   <= '0;
            cpuHold        <= 1'b1;
            loadDone       <= 1'b0;
            loadError      <= 1'b0;
            wordCount      <= '0;
            lenHi          <= '0;
            lenWords       <= '0;
            hiByte         <= '0;
            checksum       <= '0;
        end else begin
            memWriteEnable <= 1'b0;
            cpuHold        <= (stateNext != ST_DONE);
            loadDone       <= (stateNext == ST_DONE);
            loadError      <= (stateNext == ST_ERROR);
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (syncSeen) begin
                        wordCount    <= '0;
                        checksum     <= '0;
                        memWriteAddr <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (rxValid) lenHi <= rxData;
                end
                ST_LEN_LO: begin
                    if (rxValid) lenWords <= {lenHi, rxData};
                end
                ST_DATA_HI: begin
                    if (rxValid) begin
                        hiByte   <= rxData;
                        checksum <= checksum ^ rxData;
                    end
                end
                ST_DATA_LO: begin
                    if (rxValid) begin
                        checksum       <= checksum ^ rxData;
                        memWriteEnable <= 1'b1;
                        memWriteData   <= {hiByte, rxData};
                        memWriteAddr   <= wordCount[AddrWidth-1:0];
                        wordCount      <= wordCount + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a frame-level reference model.
module tb_program_loader;

    localparam int AW    = 4;
    localparam int TO    = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        rxValid = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic        memWriteEnable;
    logic [AW-1:0] memWriteAddr;
    logic [15:0] memWriteData;
    logic        cpuHold;
    logic        loadDone;
    logic        loadError;
    logic [15:0] wordCount;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCount = 0;

    logic [7:0]    txFrame[$];
    int            byteCycle[$];
    logic [AW-1:0] logAddr[$];
    logic [15:0]   logData[$];
    int            logCycle[$];
    logic [AW-1:0] expAddr[$];
    logic [15:0]   expData[$];
    int            expCycle[$];
    bit            expDone;
    logic [15:0]   expCount;

    program_loader #(
        .AddrWidth    (AW),
        .TimeoutCycles(TO)
    ) dut (
        .clk           (clk),
        .rstN          (rstN),
        .rxValid       (rxValid),
        .rxData        (rxData),
        .memWriteEnable(memWriteEnable),
        .memWriteAddr  (memWriteAddr),
        .memWriteData  (memWriteData),
        .cpuHold       (cpuHold),
        .loadDone      (loadDone),
        .loadError     (loadError),
        .wordCount     (wordCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Every cycle with the strobe high becomes one log entry.
    always @(negedge clk) begin
        if (memWriteEnable) begin
            logAddr.push_back(memWriteAddr);
            logData.push_back(memWriteData);
            logCycle.push_back(cycleCount);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rxValid = 1'b1;
        rxData  = b;
        byteCycle.push_back(cycleCount);
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic sendFrame(input int fixedGap);
        byteCycle.delete();
        logAddr.delete();
        logData.delete();
        logCycle.delete();
        foreach (txFrame[i]) begin
            sendByte(txFrame[i], (fixedGap < 0) ? int'($urandom_range(6, 0)) : fixedGap);
        end
    endtask

    task automatic buildFrame(input int n, input bit corrupt);
        logic [7:0] chk;
        logic [7:0] b;
        logic [15:0] n16;
        n16 = 16'(n);
        txFrame = {8'hA5, n16[15:8], n16[7:0]};
        if (n <= DEPTH) begin
            chk = 8'h00;
            for (int i = 0; i < 2 * n; i++) begin
                b = 8'($urandom_range(255, 0));
                txFrame.push_back(b);
                chk ^= b;
            end
            if (corrupt) chk ^= 8'($urandom_range(255, 1));
            txFrame.push_back(chk);
        end
    endtask

    // Expected outcome derived only from the frame layout and the byte timing.
    task automatic modelFrame();
        int n;
        int full;
        logic [7:0] x;
        n = int'({txFrame[1], txFrame[2]});
        expAddr.delete();
        expData.delete();
        expCycle.delete();
        full = 0;
        if (n <= DEPTH) begin
            for (int i = 0; i < n && (4 + 2 * i) < txFrame.size(); i++) begin
                expAddr.push_back(AW'(i));
                expData.push_back({txFrame[3 + 2 * i], txFrame[4 + 2 * i]});
                expCycle.push_back(byteCycle[4 + 2 * i] + 1);
                full++;
            end
        end
        expCount = 16'(full);
        expDone  = 1'b0;
        if (n <= DEPTH && txFrame.size() == 4 + 2 * n) begin
            x = 8'h00;
            for (int i = 3; i < txFrame.size() - 1; i++) x ^= txFrame[i];
            expDone = (x == txFrame[txFrame.size() - 1]);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++; if (cpuHold !== 1'b1) $display("[TB] FAIL resetHold: got %b expected 1", cpuHold); else passCount++;
        checkCount++; if (loadDone !== 1'b0) $display("[TB] FAIL resetDone: got %b expected 0", loadDone); else passCount++;
        checkCount++; if (loadError !== 1'b0) $display("[TB] FAIL resetError: got %b expected 0", loadError); else passCount++;
        checkCount++; if (memWriteEnable !== 1'b0) $display("[TB] FAIL resetWe: got %b expected 0", memWriteEnable); else passCount++;
        checkCount++; if (wordCount !== 16'h0) $display("[TB] FAIL resetCount: got %h expected 0", wordCount); else passCount++;
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        txFrame = {8'hA5, 8'h00, 8'h02, 8'h40, 8'h05, 8'hC1, 8'h23, 8'hA7};
        sendFrame(-1);
        checkCount++; if (logAddr.size() !== 2) $display("[TB] FAIL goodWrites: got %0d expected 2", logAddr.size()); else passCount++;
        if (logAddr.size() >= 2) begin
            checkCount++; if (logAddr[0] !== 4'd0 || logData[0] !== 16'h4005) $display("[TB] FAIL goodWord0: got %h@%h expected 4005@0", logData[0], logAddr[0]); else passCount++;
            checkCount++; if (logAddr[1] !== 4'd1 || logData[1] !== 16'hC123) $display("[TB] FAIL goodWord1: got %h@%h expected c123@1", logData[1], logAddr[1]); else passCount++;
            checkCount++; if (logCycle[0] !== byteCycle[4] + 1) $display("[TB] FAIL goodLatency0: got %0d expected %0d", logCycle[0], byteCycle[4] + 1); else passCount++;
            checkCount++; if (logCycle[1] !== byteCycle[6] + 1) $display("[TB] FAIL goodLatency1: got %0d expected %0d", logCycle[1], byteCycle[6] + 1); else passCount++;
        end
        checkCount++; if (loadDone !== 1'b1) $display("[TB] FAIL goodDone: got %b expected 1", loadDone); else passCount++;
        checkCount++; if (cpuHold !== 1'b0) $display("[TB] FAIL goodHold: got %b expected 0", cpuHold); else passCount++;
        checkCount++; if (wordCount !== 16'd2) $display("[TB] FAIL goodCount: got %0d expected 2", wordCount); else passCount++;
    endtask

    task automatic test_bad_checksum();
        txFrame = {8'hA5, 8'h00, 8'h02, 8'h40, 8'h05, 8'hC1, 8'h23, 8'h00};
        sendFrame(-1);
        checkCount++; if (logAddr.size() !== 2) $display("[TB] FAIL badWrites: got %0d expected 2", logAddr.size()); else passCount++;
        if (logAddr.size() >= 2) begin
            checkCount++; if (logData[1] !== 16'hC123) $display("[TB] FAIL badWord1: got %h expected c123", logData[1]); else passCount++;
        end
        checkCount++; if (loadError !== 1'b1) $display("[TB] FAIL badError: got %b expected 1", loadError); else passCount++;
        checkCount++; if (loadDone !== 1'b0) $display("[TB] FAIL badDone: got %b expected 0", loadDone); else passCount++;
        checkCount++; if (cpuHold !== 1'b1) $display("[TB] FAIL badHold: got %b expected 1", cpuHold); else passCount++;
    endtask

    task automatic test_zero_length();
        txFrame = {8'hA5, 8'h00, 8'h00, 8'h00};
        sendFrame(-1);
        checkCount++; if (logAddr.size() !== 0) $display("[TB] FAIL zeroWrites: got %0d expected 0", logAddr.size()); else passCount++;
        checkCount++; if (loadDone !== 1'b1) $display("[TB] FAIL zeroDone: got %b expected 1", loadDone); else passCount++;
        checkCount++; if (cpuHold !== 1'b0) $display("[TB] FAIL zeroHold: got %b expected 0", cpuHold); else passCount++;
    endtask

    task automatic test_timeout();
        txFrame = {8'hA5, 8'h00, 8'h01, 8'h12};
        sendFrame(0);
        repeat (TO - 1) @(negedge clk);
        checkCount++; if (loadError !== 1'b0) $display("[TB] FAIL timeoutEarly: got %b expected 0", loadError); else passCount++;
        @(negedge clk);
        checkCount++; if (loadError !== 1'b1) $display("[TB] FAIL timeoutError: got %b expected 1", loadError); else passCount++;
        checkCount++; if (cpuHold !== 1'b1) $display("[TB] FAIL timeoutHold: got %b expected 1", cpuHold); else passCount++;
        checkCount++; if (logAddr.size() !== 0) $display("[TB] FAIL timeoutWrites: got %0d expected 0", logAddr.size()); else passCount++;
        buildFrame(3, 1'b0);
        sendFrame(-1);
        checkCount++; if (loadDone !== 1'b1 || loadError !== 1'b0) $display("[TB] FAIL timeoutRecover: got done=%b err=%b expected done=1 err=0", loadDone, loadError); else passCount++;
    endtask

    task automatic test_timeout_boundary();
        txFrame = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        sendFrame(TO - 1);
        checkCount++; if (loadDone !== 1'b1 || loadError !== 1'b0) $display("[TB] FAIL edgeByteStatus: got done=%b err=%b expected done=1 err=0", loadDone, loadError); else passCount++;
        checkCount++; if (logData.size() !== 1 || logData[0] !== 16'h1234) $display("[TB] FAIL edgeByteWrite: got %0d writes expected one 1234", logData.size()); else passCount++;
    endtask

    task automatic test_oversize();
        txFrame = {8'hA5, 8'h00, 8'h11};
        sendFrame(0);
        checkCount++; if (loadError !== 1'b1) $display("[TB] FAIL oversizeError: got %b expected 1", loadError); else passCount++;
        checkCount++; if (cpuHold !== 1'b1) $display("[TB] FAIL oversizeHold: got %b expected 1", cpuHold); else passCount++;
        repeat (4) @(negedge clk);
        checkCount++; if (logAddr.size() !== 0) $display("[TB] FAIL oversizeWrites: got %0d expected 0", logAddr.size()); else passCount++;
        buildFrame(DEPTH, 1'b0);
        sendFrame(-1);
        checkCount++; if (loadDone !== 1'b1) $display("[TB] FAIL fullDepthDone: got %b expected 1", loadDone); else passCount++;
        checkCount++; if (logAddr.size() !== DEPTH) $display("[TB] FAIL fullDepthWrites: got %0d expected %0d", logAddr.size(), DEPTH); else passCount++;
        if (logAddr.size() == DEPTH) begin
            checkCount++; if (logAddr[DEPTH-1] !== 4'hF) $display("[TB] FAIL fullDepthLastAddr: got %h expected f", logAddr[DEPTH-1]); else passCount++;
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] junk;
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(1, 0) == 1) begin
                junk = 8'($urandom_range(255, 0));
                if (junk == 8'hA5) junk = 8'h5A;
                sendByte(junk, 1);
            end
            buildFrame(int'($urandom_range(20, 0)), $urandom_range(2, 0) == 0);
            sendFrame(-1);
            modelFrame();
            checkCount++; if (logAddr.size() !== expAddr.size()) $display("[TB] FAIL randWrites%0d: got %0d expected %0d", f, logAddr.size(), expAddr.size()); else passCount++;
            for (int i = 0; i < expAddr.size() && i < logAddr.size(); i++) begin
                checkCount++;
                if (logAddr[i] !== expAddr[i] || logData[i] !== expData[i] || logCycle[i] !== expCycle[i])
                    $display("[TB] FAIL randWord%0d_%0d: got %h@%h c%0d expected %h@%h c%0d", f, i, logData[i], logAddr[i], logCycle[i], expData[i], expAddr[i], expCycle[i]);
                else passCount++;
            end
            checkCount++; if (loadDone !== expDone) $display("[TB] FAIL randDone%0d: got %b expected %b", f, loadDone, expDone); else passCount++;
            checkCount++; if (loadError !== !expDone) $display("[TB] FAIL randError%0d: got %b expected %b", f, loadError, !expDone); else passCount++;
            checkCount++; if (cpuHold !== !expDone) $display("[TB] FAIL randHold%0d: got %b expected %b", f, cpuHold, !expDone); else passCount++;
            checkCount++; if (wordCount !== expCount) $display("[TB] FAIL randCount%0d: got %0d expected %0d", f, wordCount, expCount); else passCount++;
        end
    endtask

    task automatic test_reload();
        buildFrame(2, 1'b0);
        sendFrame(-1);
        checkCount++; if (loadDone !== 1'b1) $display("[TB] FAIL reloadPre: got %b expected 1", loadDone); else passCount++;
        sendByte(8'hA5, 0);
        checkCount++; if (cpuHold !== 1'b1 || loadDone !== 1'b0) $display("[TB] FAIL reloadSync: got hold=%b done=%b expected hold=1 done=0", cpuHold, loadDone); else passCount++;
        checkCount++; if (wordCount !== 16'd0) $display("[TB] FAIL reloadCount: got %0d expected 0", wordCount); else passCount++;
        txFrame = {8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (txFrame[i]) sendByte(txFrame[i], 0);
        checkCount++; if (wordCount !== 16'd2 || memWriteData !== 16'h3344) $display("[TB] FAIL midFrame: got count=%0d data=%h expected 2 3344", wordCount, memWriteData); else passCount++;
        #2 rstN = 1'b0;
        #1;
        checkCount++; if (cpuHold !== 1'b1 || loadDone !== 1'b0 || loadError !== 1'b0) $display("[TB] FAIL asyncFlags: got hold=%b done=%b err=%b expected 1 0 0", cpuHold, loadDone, loadError); else passCount++;
        checkCount++; if (memWriteAddr !== 4'h0 || memWriteData !== 16'h0 || memWriteEnable !== 1'b0) $display("[TB] FAIL asyncWrite: got we=%b addr=%h data=%h expected 0 0 0", memWriteEnable, memWriteAddr, memWriteData); else passCount++;
        checkCount++; if (wordCount !== 16'h0) $display("[TB] FAIL asyncCount: got %0d expected 0", wordCount); else passCount++;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_zero_length();
        test_timeout();
        test_timeout_boundary();
        test_oversize();
        test_random_frames();
        test_reload();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
